ysyx_25040111_scoreboard: RTL and testbench

- Parametrised register-interlock scoreboard for the execute stage; replaces the fixed 16-bit one-bit-per-register load lock.
- Tracks every in-flight long-latency write (load, CSR/late writeback) with a per-register pending counter, so repeated writes to the same register lock correctly.
- Adds a global outstanding limit, a pipeline flush and an optional same-cycle retire bypass.
- Sits between decode/issue and the EXU; gates exe_ready and is released by the arbiter finish path.

---
 rtl/ysyx_25040111_scoreboard_pkg.sv | 14 +
 rtl/ysyx_25040111_sb_cnt.sv | 35 +++
 rtl/ysyx_25040111_scoreboard.sv | 130 +++++++++++++
 tb/tb_ysyx_25040111_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_scoreboard_pkg.sv
// Shared defaults for the execute-stage register-interlock scoreboard.
// REG_AW = 4 matches the 16-register RV32E file.
package ysyx_25040111_scoreboard_pkg;

  localparam int unsigned SB_REG_AW  = 4;
  localparam int unsigned SB_MAX_OUT = 4;
  localparam int unsigned SB_CNT_W   = 3;

  // The counters must be able to represent every in-flight write without wrapping.
  function automatic bit sb_params_ok(input int unsigned cnt_w, input int unsigned max_out);
    return (max_out >= 1) && ((1 << cnt_w) > max_out);
  endfunction

endpackage

// File: rtl/ysyx_25040111_sb_cnt.sv
// Saturating up/down counter with synchronous clear. The overflow and underflow
// flags report a blocked step in the current cycle.
module ysyx_25040111_sb_cnt #(
  parameter int unsigned W   = 3,
  parameter int unsigned MAX = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf,
  output logic         unf
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // A simultaneous inc and dec cancels, so neither flag can fire in that case.
  assign ovf = inc & ~dec & ~clr & (cnt == MAX_V);
  assign unf = dec & ~inc & ~clr & (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc & ~dec & ~ovf) begin
      cnt <= cnt + 1'b1;
    end else if (dec & ~inc & ~unf) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_25040111_scoreboard.sv
// Register-interlock scoreboard. Each register has a pending-write counter, so repeated
// long-latency writes to one register stay locked until the last of them retires.
module ysyx_25040111_scoreboard
  import ysyx_25040111_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW     = SB_REG_AW,
  parameter int unsigned MAX_OUT    = SB_MAX_OUT,
  parameter int unsigned CNT_W      = SB_CNT_W,
  parameter int unsigned RET_BYPASS = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic                   iss_track,
  input  logic [REG_AW-1:0]      iss_rd,
  input  logic [REG_AW-1:0]      iss_rs1,
  input  logic                   iss_rs1_en,
  input  logic [REG_AW-1:0]      iss_rs2,
  input  logic                   iss_rs2_en,
  input  logic                   iss_rd_en,
  input  logic                   ret_valid,
  input  logic [REG_AW-1:0]      ret_rd,
  input  logic                   flush,
  output logic [(1<<REG_AW)-1:0] busy,
  output logic [CNT_W-1:0]       out_cnt,
  output logic                   full,
  output logic                   err
);

  localparam int unsigned      NREG    = 1 << REG_AW;
  localparam int unsigned      REG_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUT);
  localparam logic             BYP     = (RET_BYPASS != 0);

  if (!sb_params_ok(CNT_W, MAX_OUT)) begin : g_bad_params
    $error("scoreboard: CNT_W too small for MAX_OUT");
  end

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  reg_ovf;
  logic [NREG-1:0]  reg_unf;

  logic byp_rs1, byp_rs2, byp_rd;
  logic pend_rs1, pend_rs2, pend_rd;
  logic hazard, iss_fire, trk_req, trk_issue;
  logic ret_hit, ret_fire, ret_zero;
  logic out_inc, out_ovf, out_unf, err_set;

  // A retire that drops a count from 1 to 0 releases the hazard in the same cycle.
  assign byp_rs1  = BYP & ret_valid & (ret_rd == iss_rs1) & (cnt[iss_rs1] == CNT_ONE);
  assign byp_rs2  = BYP & ret_valid & (ret_rd == iss_rs2) & (cnt[iss_rs2] == CNT_ONE);
  assign byp_rd   = BYP & ret_valid & (ret_rd == iss_rd)  & (cnt[iss_rd]  == CNT_ONE);

  assign pend_rs1 = busy[iss_rs1] & ~byp_rs1;
  assign pend_rs2 = busy[iss_rs2] & ~byp_rs2;
  assign pend_rd  = busy[iss_rd]  & ~byp_rd;

  assign hazard    = (iss_rs1_en & pend_rs1) | (iss_rs2_en & pend_rs2) | (iss_rd_en & pend_rd);
  assign iss_ready = ~hazard & ~(iss_track & full) & ~flush;

  assign iss_fire  = iss_valid & iss_ready;
  assign trk_req   = iss_track & (iss_rd != '0);
  assign trk_issue = iss_fire & trk_req;

  // Register 0 is never tracked, and nothing issues or retires in a flush cycle.
  assign ret_hit  = ret_valid & (ret_rd != '0) & ~flush;
  assign ret_fire = ret_hit & busy[ret_rd];
  assign ret_zero = ret_hit & ~busy[ret_rd];

  assign cnt[0]     = '0;
  assign busy[0]    = 1'b0;
  assign reg_ovf[0] = 1'b0;
  assign reg_unf[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic inc;
    logic dec;

    assign inc = trk_issue & (iss_rd == REG_AW'(i));
    assign dec = ret_fire & (ret_rd == REG_AW'(i));

    ysyx_25040111_sb_cnt #(
      .W   (CNT_W),
      .MAX (REG_MAX)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (flush),
      .inc   (inc),
      .dec   (dec),
      .cnt   (cnt[i]),
      .ovf   (reg_ovf[i]),
      .unf   (reg_unf[i])
    );

    assign busy[i] = |cnt[i];
  end

  // A suppressed per-register increment must not be counted as in flight either.
  assign out_inc = trk_issue & ~(|reg_ovf);

  ysyx_25040111_sb_cnt #(
    .W   (CNT_W),
    .MAX (MAX_OUT)
  ) u_out_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (flush),
    .inc   (out_inc),
    .dec   (ret_fire),
    .cnt   (out_cnt),
    .ovf   (out_ovf),
    .unf   (out_unf)
  );

  assign full = (out_cnt == OUT_MAX);

  assign err_set = ret_zero | (|reg_ovf) | (|reg_unf) | out_ovf | out_unf;

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_scoreboard.sv
// Bench for the scoreboard: a directed vector table, then randomized traffic checked
// against a per-register pending-count model, on instances without and with retire bypass.
module tb_ysyx_25040111_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        iss_valid, iss_track, iss_rs1_en, iss_rs2_en, iss_rd_en;
  logic [3:0]  iss_rd, iss_rs1, iss_rs2, ret_rd;
  logic        ret_valid, flush;

  logic        rdy_0, rdy_1, full_0, full_1, err_0, err_1;
  logic [15:0] busy_0, busy_1;
  logic [2:0]  out_0, out_1;

  always #5 clock = ~clock;

  ysyx_25040111_scoreboard #(.RET_BYPASS(0)) dut0 (
    .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_ready(rdy_0),
    .iss_track(iss_track), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs1_en(iss_rs1_en),
    .iss_rs2(iss_rs2), .iss_rs2_en(iss_rs2_en), .iss_rd_en(iss_rd_en),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .flush(flush),
    .busy(busy_0), .out_cnt(out_0), .full(full_0), .err(err_0)
  );

  ysyx_25040111_scoreboard #(.RET_BYPASS(1)) dut1 (
    .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_ready(rdy_1),
    .iss_track(iss_track), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs1_en(iss_rs1_en),
    .iss_rs2(iss_rs2), .iss_rs2_en(iss_rs2_en), .iss_rd_en(iss_rd_en),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .flush(flush),
    .busy(busy_1), .out_cnt(out_1), .full(full_1), .err(err_1)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic v, trk, rde, rs1e, rs2e, rv, fl;
    logic [3:0] rd, rs1, rs2, rrd;
    logic rdy0, rdy1;
    logic [15:0] busy;
    logic [2:0] outc;
    logic full, err;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic trk, input int rd, input logic rde,
                              input int rs1, input logic rs1e, input int rs2, input logic rs2e,
                              input logic rv, input int rrd, input logic fl,
                              input logic rdy0, input logic rdy1, input logic [15:0] busy,
                              input int outc, input logic full, input logic err);
    vec_t t;
    t.v = v; t.trk = trk; t.rd = 4'(rd); t.rde = rde;
    t.rs1 = 4'(rs1); t.rs1e = rs1e; t.rs2 = 4'(rs2); t.rs2e = rs2e;
    t.rv = rv; t.rrd = 4'(rrd); t.fl = fl;
    t.rdy0 = rdy0; t.rdy1 = rdy1; t.busy = busy; t.outc = 3'(outc);
    t.full = full; t.err = err;
    return t;
  endfunction

  task automatic idle_inputs();
    iss_valid = 0; iss_track = 0; iss_rd = 0; iss_rd_en = 0;
    iss_rs1 = 0; iss_rs1_en = 0; iss_rs2 = 0; iss_rs2_en = 0;
    ret_valid = 0; ret_rd = 0; flush = 0;
  endtask

  // Behavioural model: one pending count per register per instance.
  localparam int MAXO = 4;
  int mc [2][16];
  int mo [2];
  bit me [2];

  function automatic bit m_pend(input int b, input int r);
    if (r == 0 || mc[b][r] == 0) return 0;
    if (b == 1 && ret_valid && int'(ret_rd) == r && mc[b][r] == 1) return 0;
    return 1;
  endfunction

  function automatic bit m_ready(input int b);
    bit hz;
    hz = (iss_rs1_en && m_pend(b, int'(iss_rs1))) || (iss_rs2_en && m_pend(b, int'(iss_rs2)))
      || (iss_rd_en && m_pend(b, int'(iss_rd)));
    return !hz && !(iss_track && mo[b] == MAXO) && !flush;
  endfunction

  function automatic void m_clear(input int b, input bit with_err);
    for (int r = 0; r < 16; r++) mc[b][r] = 0;
    mo[b] = 0;
    if (with_err) me[b] = 0;
  endfunction

  function automatic void m_update(input int b, input bit rdy, input bit rst);
    bit iss, ret;
    int rd, rr;
    if (rst) begin m_clear(b, 1); return; end
    if (flush) begin m_clear(b, 0); return; end
    rd  = int'(iss_rd);
    rr  = int'(ret_rd);
    iss = iss_valid && rdy && iss_track && rd != 0;
    ret = ret_valid && rr != 0;
    if (ret && mc[b][rr] == 0) begin me[b] = 1; ret = 0; end
    if (iss && mc[b][rd] == 7 && !(ret && rr == rd)) begin me[b] = 1; iss = 0; end
    if (iss) begin mc[b][rd]++; mo[b]++; end
    if (ret) begin mc[b][rr]--; mo[b]--; end
  endfunction

  function automatic logic [15:0] m_busy(input int b);
    logic [15:0] v = '0;
    for (int r = 1; r < 16; r++) v[r] = (mc[b][r] != 0);
    return v;
  endfunction

  vec_t tbl [25];

  initial begin
    bit exp_rdy [2];
    bit rst_now;

    tbl[0]  = mk(1,1,5,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h0020,1,0,0);
    tbl[1]  = mk(1,0,0,0,  5,1, 0,0, 0,0,  0, 0,0, 16'h0020,1,0,0);
    tbl[2]  = mk(1,0,0,0,  5,1, 0,0, 1,5,  0, 0,1, 16'h0000,0,0,0);
    tbl[3]  = mk(1,0,0,0,  5,1, 0,0, 0,0,  0, 1,1, 16'h0000,0,0,0);
    tbl[4]  = mk(1,1,7,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h0080,1,0,0);
    tbl[5]  = mk(1,1,7,0,  0,0, 0,0, 0,0,  0, 1,1, 16'h0080,2,0,0);
    tbl[6]  = mk(0,0,0,0,  0,0, 0,0, 1,7,  0, 1,1, 16'h0080,1,0,0);
    tbl[7]  = mk(0,0,0,0,  0,0, 7,1, 1,7,  0, 0,1, 16'h0000,0,0,0);
    tbl[8]  = mk(1,1,1,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h0002,1,0,0);
    tbl[9]  = mk(1,1,2,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h0006,2,0,0);
    tbl[10] = mk(1,1,3,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h000E,3,0,0);
    tbl[11] = mk(1,1,4,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h001E,4,1,0);
    tbl[12] = mk(1,1,6,1,  0,0, 0,0, 0,0,  0, 0,0, 16'h001E,4,1,0);
    tbl[13] = mk(1,0,6,1,  8,1, 0,0, 0,0,  0, 1,1, 16'h001E,4,1,0);
    tbl[14] = mk(0,0,0,0,  0,0, 0,0, 1,3,  0, 1,1, 16'h0016,3,0,0);
    tbl[15] = mk(0,0,0,0,  0,0, 0,0, 1,4,  0, 1,1, 16'h0006,2,0,0);
    tbl[16] = mk(1,1,3,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h000E,3,0,0);
    tbl[17] = mk(1,1,3,0,  0,0, 0,0, 1,3,  0, 1,1, 16'h000E,3,0,0);
    tbl[18] = mk(0,0,0,0,  0,0, 3,1, 1,3,  0, 0,1, 16'h0006,2,0,0);
    tbl[19] = mk(1,1,0,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h0006,2,0,0);
    tbl[20] = mk(0,0,0,0,  0,0, 0,0, 1,9,  0, 1,1, 16'h0006,2,0,1);
    tbl[21] = mk(1,1,9,1,  0,0, 0,0, 0,0,  0, 1,1, 16'h0206,3,0,1);
    tbl[22] = mk(1,1,10,1, 0,0, 0,0, 1,1,  1, 0,0, 16'h0000,0,0,1);
    tbl[23] = mk(1,1,10,1, 0,0, 0,0, 0,0,  0, 1,1, 16'h0400,1,0,1);
    tbl[24] = mk(0,0,0,0,  0,0, 0,0, 1,10, 0, 1,1, 16'h0000,0,0,1);

    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy0", 32'(busy_0), 0);
    check("reset out0",  32'(out_0),  0);
    check("reset full0", 32'(full_0), 0);
    check("reset err0",  32'(err_0),  0);
    check("reset busy1", 32'(busy_1), 0);
    check("reset out1",  32'(out_1),  0);
    @(negedge clock);
    reset = 0;

    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      iss_valid = tbl[i].v; iss_track = tbl[i].trk; iss_rd = tbl[i].rd; iss_rd_en = tbl[i].rde;
      iss_rs1 = tbl[i].rs1; iss_rs1_en = tbl[i].rs1e; iss_rs2 = tbl[i].rs2; iss_rs2_en = tbl[i].rs2e;
      ret_valid = tbl[i].rv; ret_rd = tbl[i].rrd; flush = tbl[i].fl;
      #1;
      check($sformatf("row%0d rdy0", i), 32'(rdy_0), 32'(tbl[i].rdy0));
      check($sformatf("row%0d rdy1", i), 32'(rdy_1), 32'(tbl[i].rdy1));
      @(posedge clock);
      #1;
      check($sformatf("row%0d busy0", i), 32'(busy_0), 32'(tbl[i].busy));
      check($sformatf("row%0d out0",  i), 32'(out_0),  32'(tbl[i].outc));
      check($sformatf("row%0d full0", i), 32'(full_0), 32'(tbl[i].full));
      check($sformatf("row%0d err0",  i), 32'(err_0),  32'(tbl[i].err));
      check($sformatf("row%0d busy1", i), 32'(busy_1), 32'(tbl[i].busy));
      check($sformatf("row%0d out1",  i), 32'(out_1),  32'(tbl[i].outc));
      check($sformatf("row%0d full1", i), 32'(full_1), 32'(tbl[i].full));
      check($sformatf("row%0d err1",  i), 32'(err_1),  32'(tbl[i].err));
    end

    // Randomized traffic; reset first so both model instances start clean.
    @(negedge clock);
    idle_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
    m_clear(0, 1);
    m_clear(1, 1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      rst_now    = ($urandom_range(0, 199) == 0);
      reset      = rst_now;
      iss_valid  = ($urandom_range(0, 3) != 0);
      iss_track  = $urandom_range(0, 1) == 1;
      iss_rd     = 4'($urandom_range(0, 7));
      iss_rd_en  = $urandom_range(0, 1) == 1;
      iss_rs1    = 4'($urandom_range(0, 7));
      iss_rs1_en = $urandom_range(0, 1) == 1;
      iss_rs2    = 4'($urandom_range(0, 7));
      iss_rs2_en = $urandom_range(0, 1) == 1;
      flush      = ($urandom_range(0, 39) == 0);
      ret_valid  = ($urandom_range(0, 2) != 0);
      ret_rd     = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) begin
        for (int k = 0; k < 8; k++) begin
          if (mc[0][(int'(ret_rd) + k) % 8] != 0) begin
            ret_rd = 4'((int'(ret_rd) + k) % 8);
            break;
          end
        end
      end
      #1;
      exp_rdy[0] = m_ready(0);
      exp_rdy[1] = m_ready(1);
      check($sformatf("rnd%0d rdy0", c), 32'(rdy_0), 32'(exp_rdy[0]));
      check($sformatf("rnd%0d rdy1", c), 32'(rdy_1), 32'(exp_rdy[1]));
      m_update(0, exp_rdy[0], rst_now);
      m_update(1, exp_rdy[1], rst_now);
      @(posedge clock);
      #1;
      check($sformatf("rnd%0d busy0", c), 32'(busy_0), 32'(m_busy(0)));
      check($sformatf("rnd%0d out0",  c), 32'(out_0),  32'(mo[0]));
      check($sformatf("rnd%0d full0", c), 32'(full_0), 32'(mo[0] == MAXO));
      check($sformatf("rnd%0d err0",  c), 32'(err_0),  32'(me[0]));
      check($sformatf("rnd%0d busy1", c), 32'(busy_1), 32'(m_busy(1)));
      check($sformatf("rnd%0d out1",  c), 32'(out_1),  32'(mo[1]));
      check($sformatf("rnd%0d full1", c), 32'(full_1), 32'(mo[1] == MAXO));
      check($sformatf("rnd%0d err1",  c), 32'(err_1),  32'(me[1]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
